mac_vec: RTL and testbench
==========================

Name: mac_vec

Overview:
- Multi-lane successor to the scalar fixed-point MAC.
- Each input beat carries NUM_LANES signed A/B operand pairs on two independent valid/ready/last streams.
- Per beat: forms NUM_LANES products, reduces them through a registered adder tree, and accumulates across beats until the packet's last beat.
- Emits one rounded, saturated-or-wrapped fixed-point dot product per packet on a valid/ready/last output stream. Sits between operand streamers and the result sink in the datapath.

Parameters:
- NUM_LANES, 4, operand pairs per beat; power of 2, 1..16.
- INT_A, 8, integer bits of A (sign included).
- FRAC_A, 8, fractional bits of A.
- INT_B, 8, integer bits of B.
- FRAC_B, 8, fractional bits of B.
- INT_OUT, 16, integer bits of m_data.
- FRAC_OUT, 16, fractional bits of m_data.
- ACC_GUARD, 9, extra accumulator bits; a packet of up to 2^ACC_GUARD beats cannot overflow the accumulator.
- SAT_EN, 1, 1 = saturate on output overflow, 0 = wrap.
- ROUND_EN, 1, 1 = round-half-up when discarding fraction bits, 0 = truncate.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- s_valid_a, in, 1, A beat valid.
- s_ready_a, out, 1, A beat accepted.
- s_last_a, in, 1, last A beat of packet.
- A_in, in, NUM_LANES*(INT_A+FRAC_A), packed signed lanes; lane 0 in the LSBs.
- s_valid_b, in, 1, B beat valid.
- s_ready_b, out, 1, B beat accepted.
- s_last_b, in, 1, last B beat of packet.
- B_in, in, NUM_LANES*(INT_B+FRAC_B), packed signed lanes.
- m_data, out, INT_OUT+FRAC_OUT, signed packet result.
- m_valid, out, 1, result valid.
- m_ready, in, 1, sink accepts result.
- m_last, out, 1, equals m_valid; one result per packet.
- overflow_flg, out, 1, result exceeded the positive output range; qualified by m_valid.
- underflow_flg, out, 1, result below the negative output range; qualified by m_valid.
- last_err, out, 1, sticky: s_last_a != s_last_b on an accepted beat.

Behaviour:
- Reset (synchronous, priority over everything):
  - All outputs 0.
  - Pipeline valids, accumulator and last_err cleared.
  - A reset mid-packet discards the partial sum; the next accepted beat starts a new packet.
- Stall and join:
  - stall = m_valid & ~m_ready.
  - s_ready_a = ~stall & s_valid_b; s_ready_b = ~stall & s_valid_a.
  - A beat is accepted when s_valid_a & s_valid_b & ~stall. No beat is consumed from only one stream.
  - While stall is high, every pipeline stage holds.
- Pipeline, with beat accepted at edge k:
  - S1 (edge k): registers NUM_LANES full-precision products, width INT_A+INT_B+FRAC_A+FRAC_B, frac FA+FB.
  - S2 (edge k+1): registers the adder-tree sum, width product + clog2(NUM_LANES).
  - S3 (edge k+2): acc <= acc_base + sum. acc_base is 0 if the previous accumulated beat closed a packet, otherwise acc. Accumulator width = tree width + ACC_GUARD.
- Last handling:
  - Beat last = s_last_a | s_last_b. It travels with the beat through the pipeline.
  - When a last beat reaches S3, the converted value of acc_base + sum is loaded into the output register at the same edge.
  - m_valid therefore rises at edge k+2 for a last beat accepted at edge k: the result is visible 3 cycles after acceptance.
- Back-to-back packets are allowed at full rate, with no bubble.
- Conversion:
  - Align FA+FB to FRAC_OUT. If FA+FB > FRAC_OUT, arithmetic shift right by the difference; with ROUND_EN, add half-LSB before the shift. If FA+FB < FRAC_OUT, shift left.
  - Range check against [-2^(W-1), 2^(W-1)-1], where W = INT_OUT+FRAC_OUT.
  - SAT_EN=1: clamp to the bound.
  - SAT_EN=0: keep the low W bits.
  - overflow_flg and underflow_flg are set in either mode and are registered with m_data.
- Output handshake:
  - m_data and the flags are held stable while m_valid & ~m_ready.
  - The output register clears m_valid on m_ready unless a new result loads in the same edge.
  - Single-beat packets (last on the first beat) are legal.
- last_err is cleared only by reset.

Decomposition:
- Package mac_pkg holds:
  - Width functions: prod_w, tree_w, acc_w, out_w.
  - Saturation bound constants.
  - The convert/saturate function, shared with the scalar MAC.
- One sub-module, mac_add_tree: parametrised registered adder tree. NUM_LANES inputs, one pipeline register at the root, stall enable input.

Test Plan:
- Basic packet: defaults; all lanes A=0x0100 (1.0), B=0x0200 (2.0); 3 beats, last on beat 3 -> m_data=0x0018_0000 (24.0), flags 0, m_valid 3 cycles after the last acceptance.
- Saturation: all lanes A=0x7FFF, B=0x7FFF; 1-beat packet -> m_data=0x7FFF_FFFF, overflow_flg=1. Same with A=0x8000 -> m_data=0x8000_0000, underflow_flg=1. Rebuild with SAT_EN=0 -> m_data equals the low 32 bits of the exact sum, flag still 1.
- Back-pressure: hold m_ready=0 after a result while the next packet's beats are offered -> s_ready_a=s_ready_b=0, m_data unchanged. Release m_ready -> second packet result correct, no beat lost or duplicated.
- Join/throttle: toggle s_valid_a independently of s_valid_b with random gaps over 100 beats (B incrementing by 1, A constant 0x1000) -> result matches the reference model; no acceptance without both valids.
- Last mismatch and reset: s_last_a=1, s_last_b=0 on beat 2 -> packet closes at beat 2, last_err=1. Assert reset mid-packet -> outputs 0 the next cycle; the following 2-beat packet result excludes any pre-reset beats.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared fixed-point helpers for the MAC family: width arithmetic, saturation
// bounds and the align/round/saturate conversion used on every output path.
package mac_pkg;

    localparam int MAX_W = 128;
    localparam logic signed [MAX_W-1:0] ONE = MAX_W'(1);

    typedef struct packed {
        logic [63:0] data;
        logic        ovf;
        logic        unf;
    } conv_t;

    function automatic int prod_w(input int int_a, input int frac_a,
                                  input int int_b, input int frac_b);
        return int_a + frac_a + int_b + frac_b;
    endfunction

    function automatic int tree_w(input int pw, input int lanes);
        return pw + $clog2(lanes);
    endfunction

    function automatic int acc_w(input int tw, input int guard);
        return tw + guard;
    endfunction

    function automatic int out_w(input int int_out, input int frac_out);
        return int_out + frac_out;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_hi(input int w);
        return (ONE <<< (w - 1)) - ONE;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_lo(input int w);
        return -(ONE <<< (w - 1));
    endfunction

    function automatic conv_t convert(input logic signed [MAX_W-1:0] v,
                                      input int frac_in, input int frac_out,
                                      input int w, input bit round_en,
                                      input bit sat_en);
        logic signed [MAX_W-1:0] x;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        conv_t r;
        x = v;
        // Half-LSB bias before the arithmetic shift gives round-half-up.
        if (frac_in > frac_out) begin
            if (round_en) x = x + (ONE <<< (frac_in - frac_out - 1));
            x = x >>> (frac_in - frac_out);
        end else if (frac_in < frac_out) begin
            x = x <<< (frac_out - frac_in);
        end
        hi = sat_hi(w);
        lo = sat_lo(w);
        r.ovf  = (x > hi);
        r.unf  = (x < lo);
        r.data = x[63:0];
        if (sat_en && r.ovf) r.data = hi[63:0];
        if (sat_en && r.unf) r.data = lo[63:0];
        return r;
    endfunction

endpackage

// File: rtl/mac_add_tree.sv
// Balanced adder tree over NUM_LANES signed products with a single register
// at the root; the register holds while en is low.
module mac_add_tree
    import mac_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PROD_W    = 32,
    parameter int TREE_W    = 34
) (
    input  logic                          clk,
    input  logic                          en,
    input  logic [NUM_LANES*PROD_W-1:0]   prod,
    output logic signed [TREE_W-1:0]      sum
);

    // Heap layout: leaves at NUM_LANES-1.., node j sums children 2j+1 and 2j+2.
    logic signed [TREE_W-1:0] node [2*NUM_LANES-1];

    always_comb begin
        node = '{default: '0};
        for (int i = 0; i < NUM_LANES; i++)
            node[NUM_LANES-1+i] = TREE_W'($signed(prod[i*PROD_W +: PROD_W]));
        for (int j = NUM_LANES - 2; j >= 0; j--)
            node[j] = node[2*j+1] + node[2*j+2];
    end

    always_ff @(posedge clk) begin
        if (en) sum <= node[0];
    end

endmodule

// File: rtl/mac_vec.sv
// Multi-lane fixed-point dot-product MAC: joins two operand streams, multiplies
// lane-wise, reduces through a registered tree and accumulates per packet.
module mac_vec
    import mac_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int INT_A     = 8,
    parameter int FRAC_A    = 8,
    parameter int INT_B     = 8,
    parameter int FRAC_B    = 8,
    parameter int INT_OUT   = 16,
    parameter int FRAC_OUT  = 16,
    parameter int ACC_GUARD = 9,
    parameter int SAT_EN    = 1,
    parameter int ROUND_EN  = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   s_valid_a,
    output logic                                   s_ready_a,
    input  logic                                   s_last_a,
    input  logic [NUM_LANES*(INT_A+FRAC_A)-1:0]    A_in,
    input  logic                                   s_valid_b,
    output logic                                   s_ready_b,
    input  logic                                   s_last_b,
    input  logic [NUM_LANES*(INT_B+FRAC_B)-1:0]    B_in,
    output logic signed [INT_OUT+FRAC_OUT-1:0]     m_data,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic                                   m_last,
    output logic                                   overflow_flg,
    output logic                                   underflow_flg,
    output logic                                   last_err
);

    localparam int AW     = INT_A + FRAC_A;
    localparam int BW     = INT_B + FRAC_B;
    localparam int PW     = prod_w(INT_A, FRAC_A, INT_B, FRAC_B);
    localparam int TW     = tree_w(PW, NUM_LANES);
    localparam int ACCW   = acc_w(TW, ACC_GUARD);
    localparam int OUT_W  = out_w(INT_OUT, FRAC_OUT);
    localparam int FRAC_P = FRAC_A + FRAC_B;

    logic stall;
    logic accept;

    assign stall     = m_valid & ~m_ready;
    assign s_ready_a = ~reset & ~stall & s_valid_b;
    assign s_ready_b = ~reset & ~stall & s_valid_a;
    assign accept    = ~reset & ~stall & s_valid_a & s_valid_b;
    assign m_last    = m_valid;

    // S1: lane products
    logic [NUM_LANES*PW-1:0] prod_c;
    logic [NUM_LANES*PW-1:0] prod_p0;
    logic                    vld_p0;
    logic                    last_p0;

    always_comb begin
        prod_c = '0;
        for (int l = 0; l < NUM_LANES; l++)
            prod_c[l*PW +: PW] = PW'($signed(A_in[l*AW +: AW])) * PW'($signed(B_in[l*BW +: BW]));
    end

    always_ff @(posedge clk) begin
        if (accept) prod_p0 <= prod_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else if (!stall) begin
            vld_p0  <= accept;
            last_p0 <= s_last_a | s_last_b;
        end
    end

    // S2: adder-tree root register
    logic signed [TW-1:0] sum_p1;
    logic                 vld_p1;
    logic                 last_p1;

    mac_add_tree #(
        .NUM_LANES (NUM_LANES),
        .PROD_W    (PW),
        .TREE_W    (TW)
    ) u_tree (
        .clk  (clk),
        .en   (~stall),
        .prod (prod_p0),
        .sum  (sum_p1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    // S3: accumulate, convert and load the output register on a last beat
    logic signed [ACCW-1:0] acc_p2;
    logic                   open_p2;
    logic signed [ACCW-1:0] acc_base;
    logic signed [ACCW-1:0] acc_next;
    conv_t                  conv;

    always_comb begin
        acc_base = open_p2 ? acc_p2 : '0;
        acc_next = acc_base + ACCW'(sum_p1);
    end

    assign conv = convert(MAX_W'(acc_next), FRAC_P, FRAC_OUT, OUT_W,
                          ROUND_EN != 0, SAT_EN != 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p2        <= '0;
            open_p2       <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            overflow_flg  <= 1'b0;
            underflow_flg <= 1'b0;
            last_err      <= 1'b0;
        end else begin
            if (!stall && vld_p1) begin
                acc_p2  <= acc_next;
                open_p2 <= ~last_p1;
            end
            if (!stall && vld_p1 && last_p1) begin
                m_valid       <= 1'b1;
                m_data        <= OUT_W'(conv.data);
                overflow_flg  <= conv.ovf;
                underflow_flg <= conv.unf;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept && (s_last_a != s_last_b)) last_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_vec.sv
// Bench for mac_vec: table of single-lane-pattern packets plus hand sequences
// for latency, back-pressure, join throttling, last mismatch and reset.
module tb_mac_vec;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid_a, s_last_a, s_valid_b, s_last_b, m_ready;
    logic [63:0] A_in, B_in;

    logic        s_ready_a, s_ready_b, m_valid, m_last, overflow_flg, underflow_flg, last_err;
    logic [31:0] m_data;
    logic        s_ready_a_w, s_ready_b_w, m_valid_w, m_last_w, ovf_w, unf_w, last_err_w;
    logic [31:0] m_data_w;
    logic        s_ready_a_r, s_ready_b_r, m_valid_r, m_last_r, ovf_r, unf_r, last_err_r;
    logic [27:0] m_data_r;

    always #5 clk = ~clk;

    mac_vec dut (
        .clk(clk), .reset(reset),
        .s_valid_a(s_valid_a), .s_ready_a(s_ready_a), .s_last_a(s_last_a), .A_in(A_in),
        .s_valid_b(s_valid_b), .s_ready_b(s_ready_b), .s_last_b(s_last_b), .B_in(B_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .overflow_flg(overflow_flg), .underflow_flg(underflow_flg), .last_err(last_err)
    );

    mac_vec #(.SAT_EN(0)) dut_w (
        .clk(clk), .reset(reset),
        .s_valid_a(s_valid_a), .s_ready_a(s_ready_a_w), .s_last_a(s_last_a), .A_in(A_in),
        .s_valid_b(s_valid_b), .s_ready_b(s_ready_b_w), .s_last_b(s_last_b), .B_in(B_in),
        .m_data(m_data_w), .m_valid(m_valid_w), .m_ready(m_ready), .m_last(m_last_w),
        .overflow_flg(ovf_w), .underflow_flg(unf_w), .last_err(last_err_w)
    );

    mac_vec #(.FRAC_OUT(12), .ROUND_EN(1)) dut_r (
        .clk(clk), .reset(reset),
        .s_valid_a(s_valid_a), .s_ready_a(s_ready_a_r), .s_last_a(s_last_a), .A_in(A_in),
        .s_valid_b(s_valid_b), .s_ready_b(s_ready_b_r), .s_last_b(s_last_b), .B_in(B_in),
        .m_data(m_data_r), .m_valid(m_valid_r), .m_ready(m_ready), .m_last(m_last_r),
        .overflow_flg(ovf_r), .underflow_flg(unf_r), .last_err(last_err_r)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint      exact;
        logic [31:0] exp;
        bit          ovf;
        bit          unf;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          beats;
        logic [31:0] exp;
        bit          ovf;
        bit          unf;
    } vec_t;

    longint      model_acc = 0;
    bit          tbl_valid = 1'b0;
    logic [31:0] tbl_exp;
    bit          tbl_ovf, tbl_unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint dot(input logic [63:0] a, input logic [63:0] b);
        longint s = 0;
        for (int l = 0; l < 4; l++)
            s += longint'($signed(a[l*16 +: 16])) * longint'($signed(b[l*16 +: 16]));
        return s;
    endfunction

    // Reference conversion from an exact sum with 16 fraction bits.
    function automatic void model_conv(input longint v, input int fo, input int w, input bit sat,
                                       output longint d, output bit o, output bit u);
        longint x = v;
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        if (fo < 16) x = (x + (longint'(1) <<< (16 - fo - 1))) >>> (16 - fo);
        o = (x > hi);
        u = (x < lo);
        if (sat && o) x = hi;
        if (sat && u) x = lo;
        d = x & ((longint'(1) <<< w) - 1);
    endfunction

    task automatic push_result();
        sb_t    e;
        longint d;
        bit     o, u;
        e.exact = model_acc;
        if (tbl_valid) begin
            e.exp = tbl_exp; e.ovf = tbl_ovf; e.unf = tbl_unf;
        end else begin
            model_conv(model_acc, 16, 32, 1'b1, d, o, u);
            e.exp = d[31:0]; e.ovf = o; e.unf = u;
        end
        sbq.push_back(e);
        model_acc = 0;
    endtask

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b,
                             input bit la, input bit lb, input bit thr);
        int n = 0;
        bit fired = 1'b0;
        logic exp_ra, exp_rb;
        A_in = a; B_in = b; s_last_a = la; s_last_b = lb;
        s_valid_a = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        s_valid_b = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fired) begin
            if (thr) m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (thr) begin
                exp_ra = s_valid_b && !(m_valid && !m_ready);
                exp_rb = s_valid_a && !(m_valid && !m_ready);
                check("join_ready", 64'({s_ready_a, s_ready_a_w, s_ready_a_r, s_ready_b}),
                      64'({exp_ra, exp_ra, exp_ra, exp_rb}));
            end
            fired = s_valid_a && s_valid_b && s_ready_a && s_ready_b;
            @(posedge clk); #1;
            if (fired) begin
                model_acc += dot(a, b);
                if (la || lb) push_result();
            end else begin
                if (thr && !s_valid_a) s_valid_a = 1'($urandom_range(0, 1));
                if (thr && !s_valid_b) s_valid_b = 1'($urandom_range(0, 1));
                n++;
                if (n > 200) begin
                    check("accept_timeout", 64'(n), 64'(0));
                    break;
                end
            end
        end
        s_valid_a = 1'b0; s_valid_b = 1'b0; s_last_a = 1'b0; s_last_b = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue", 64'(sbq.size()), 64'(0));
        #1;
    endtask

    sb_t    mon_e;
    longint mon_d;
    bit     mon_o, mon_u;

    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 64'(m_data), 64'hDEAD_0000_0000_0000);
            end else begin
                mon_e = sbq.pop_front();
                check("m_data", 64'(m_data), 64'(mon_e.exp));
                check("flags", 64'({overflow_flg, underflow_flg}), 64'({mon_e.ovf, mon_e.unf}));
                check("m_last", 64'({m_last, m_valid_w, m_last_w, m_valid_r, m_last_r}), 64'(5'b11111));
                model_conv(mon_e.exact, 16, 32, 1'b0, mon_d, mon_o, mon_u);
                check("wrap_data", 64'(m_data_w), mon_d);
                check("wrap_flags", 64'({ovf_w, unf_w}), 64'({mon_o, mon_u}));
                model_conv(mon_e.exact, 12, 28, 1'b1, mon_d, mon_o, mon_u);
                check("round_data", 64'(m_data_r), mon_d);
                check("round_flags", 64'({ovf_r, unf_r}), 64'({mon_o, mon_u}));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{16'h0100, 16'h0200, 3, 32'h0018_0000, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 1, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h7FFF, 1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{16'hFF00, 16'h0300, 2, 32'hFFE8_0000, 1'b0, 1'b0};
        vecs[5] = '{16'h0001, 16'h0002, 1, 32'h0000_0008, 1'b0, 1'b0};
        vecs[6] = '{16'h0001, 16'hFFFF, 1, 32'hFFFF_FFFC, 1'b0, 1'b0};

        reset = 1'b1; m_ready = 1'b1;
        s_valid_a = 1'b0; s_last_a = 1'b0; s_valid_b = 1'b1; s_last_b = 1'b0;
        A_in = '0; B_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({m_valid, m_last, overflow_flg, underflow_flg, last_err, s_ready_a}), 64'(0));
        check("reset_data", 64'(m_data), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0; s_valid_b = 1'b0;

        // Table of packets, streamed back to back.
        foreach (vecs[i]) begin
            tbl_valid = 1'b1;
            tbl_exp = vecs[i].exp; tbl_ovf = vecs[i].ovf; tbl_unf = vecs[i].unf;
            for (int k = 0; k < vecs[i].beats; k++) begin
                send_beat({4{vecs[i].a}}, {4{vecs[i].b}}, k == vecs[i].beats - 1,
                          k == vecs[i].beats - 1, 1'b0);
            end
            tbl_valid = 1'b0;
        end
        wait_idle();

        // Latency: result appears on the third edge after the last acceptance.
        send_beat({4{16'h0100}}, {4{16'h0200}}, 1'b0, 1'b0, 1'b0);
        send_beat({4{16'h0100}}, {4{16'h0200}}, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("latency_early", 64'(m_valid), 64'(0));
        @(negedge clk);
        check("latency_due", 64'(m_valid), 64'(1));
        wait_idle();

        // Back-pressure: the held result blocks the next packet.
        m_ready = 1'b0;
        send_beat({4{16'h0100}}, {4{16'h0100}}, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_result_valid", 64'(m_valid), 64'(1));
        fork
            begin
                send_beat({4{16'h0200}}, {4{16'h0100}}, 1'b0, 1'b0, 1'b0);
                send_beat({4{16'h0200}}, {4{16'h0100}}, 1'b1, 1'b1, 1'b0);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_ready", 64'({s_ready_a, s_ready_b, m_valid}), 64'(3'b001));
                    check("bp_hold", 64'(m_data), 64'h0004_0000);
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        wait_idle();

        // Join/throttle: independent random valids and random sink stalls.
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 10; k++) begin
                int i = p * 10 + k;
                send_beat({4{16'h1000}}, {16'(i + 3), 16'(i + 2), 16'(i + 1), 16'(i)},
                          k == 9, k == 9, 1'b1);
            end
        end
        m_ready = 1'b1;
        wait_idle();

        // Last mismatch closes the packet and sets the sticky error.
        send_beat({4{16'h0100}}, {4{16'h0100}}, 1'b0, 1'b0, 1'b0);
        send_beat({4{16'h0100}}, {4{16'h0100}}, 1'b1, 1'b0, 1'b0);
        send_beat({4{16'h0300}}, {4{16'h0100}}, 1'b1, 1'b1, 1'b0);
        wait_idle();
        check("last_err_set", 64'({last_err, last_err_w, last_err_r}), 64'(3'b111));

        // Reset mid-packet with a held result and a partial sum pending.
        m_ready = 1'b0;
        send_beat({4{16'h0300}}, {4{16'h0100}}, 1'b1, 1'b1, 1'b0);
        send_beat({4{16'h0100}}, {4{16'h0100}}, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_valid", 64'(m_valid), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        sbq.delete();
        model_acc = 0;
        @(negedge clk);
        check("mid_reset_outputs", 64'({m_valid, m_last, overflow_flg, underflow_flg, last_err}), 64'(0));
        check("mid_reset_data", 64'({m_data, m_data_w}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0; m_ready = 1'b1;
        tbl_valid = 1'b1; tbl_exp = 32'h0010_0000; tbl_ovf = 1'b0; tbl_unf = 1'b0;
        send_beat({4{16'h0200}}, {4{16'h0100}}, 1'b0, 1'b0, 1'b0);
        send_beat({4{16'h0200}}, {4{16'h0100}}, 1'b1, 1'b1, 1'b0);
        tbl_valid = 1'b0;
        wait_idle();
        check("last_err_after_reset", 64'(last_err), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
